// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the score display controller:
//   - active-low 7-segment encodings (bit order gfedcba) for 0..9 and blank
//   - controller FSM state encoding
//   - number of BCD digits produced per channel
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int BCD_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Combinational BCD digit to active-low 7-segment mapper.
// Ports:
//   digit  in   4  BCD digit code; codes above 9 display blank
//   blank  in   1  force the digit dark
//   seg    out  7  active-low segments, bit order gfedcba
// -----------------------------------------------------------------------------
module seg7_digit
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
// Two requesters share one sequential shift-add-3 binary-to-BCD converter.
// Requests are granted round-robin; each finished conversion is written into
// that channel's three digit registers, which drive the HEX displays.
//
// Ports:
//   clock   in   1      system clock
//   reset   in   1      synchronous, active-high reset
//   req     in   2      level-sensitive conversion request per channel
//   value0  in   WIDTH  channel 0 binary value, sampled at grant
//   value1  in   WIDTH  channel 1 binary value, sampled at grant
//   ack     out  2      one-cycle pulse when a channel's digits were updated
//   busy    out  1      high while a conversion is in progress
//   hex0..2 out  7      channel 0 ones / tens / hundreds segments (active-low)
//   hex3..5 out  7      channel 1 ones / tens / hundreds segments (active-low)
//
// Build option: define SCORE_DISPLAY_BLANK_LEADING_EN to blank leading zeros
// (hundreds blank when 0, tens blank when hundreds and tens are both 0).
// -----------------------------------------------------------------------------
module score_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] value0,
    input  logic [WIDTH-1:0] value1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam int NUM_DIGITS = 2 * BCD_DIGITS;

    state_t             state_reg, state_next;
    logic               ptr_reg, ptr_next;
    logic               ch_reg, ch_next;
    logic [WIDTH-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         digit_reg [NUM_DIGITS];

    logic               grant;
    logic               digit_we;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic               unused_bcd_msb;
    logic [6:0]         seg [NUM_DIGITS];
    logic               blank [NUM_DIGITS];

    // Add-3 correction on every nibble that would overflow when doubled.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_reg[4*gi +: 4] + 4'd3
                                  : bcd_reg[4*gi +: 4];
    end

    // One shift-add-3 iteration: the binary MSB enters the BCD LSB. With at
    // most 9 input bits the hundreds digit never exceeds 5, so the top bit of
    // the corrected accumulator is always zero and is dropped.
    assign bcd_shift      = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
    assign unused_bcd_msb = bcd_adj[BCD_W-1];

    // With both channels requesting, the pointer decides; otherwise the only
    // requester wins (req[1] alone selects channel 1).
    assign grant = (req[0] && req[1]) ? ptr_reg : req[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            ch_reg    <= 1'b0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            ch_reg    <= ch_next;
            bin_reg   <= bin_next;
            bcd_reg   <= bcd_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ch_next    = ch_reg;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        cnt_next   = cnt_reg;
        digit_we   = 1'b0;
        ack        = 2'b00;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = SHIFT;
                    ch_next    = grant;
                    ptr_next   = ~grant;
                    bin_next   = grant ? value1 : value0;
                    bcd_next   = '0;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                bcd_next = bcd_shift;
                bin_next = bin_reg << 1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    // Final iteration: the shifted value is the finished result.
                    digit_we   = 1'b1;
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                ack[ch_reg] = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Digit storage: index = channel*3 + position (0 ones, 1 tens, 2 hundreds).
    // Only the granted channel's digits are written.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam int CH  = gi / BCD_DIGITS;
        localparam int POS = gi % BCD_DIGITS;

        always_ff @(posedge clock) begin
            if (reset) begin
                digit_reg[gi] <= 4'd0;
            end else if (digit_we && (ch_reg == 1'(CH))) begin
                digit_reg[gi] <= bcd_shift[4*POS +: 4];
            end
        end

`ifdef SCORE_DISPLAY_BLANK_LEADING_EN
        if (POS == 2) begin : g_blank_hund
            assign blank[gi] = (digit_reg[gi] == 4'd0);
        end else if (POS == 1) begin : g_blank_tens
            assign blank[gi] = (digit_reg[gi] == 4'd0) && (digit_reg[gi+1] == 4'd0);
        end else begin : g_blank_ones
            assign blank[gi] = 1'b0;
        end
`else
        assign blank[gi] = 1'b0;
`endif

        seg7_digit u_seg (
            .digit (digit_reg[gi]),
            .blank (blank[gi]),
            .seg   (seg[gi])
        );
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];

endmodule
